// File: rtl/intra_block_sequencer.sv
// Raster-order 4x4 block request generator for an intra predictor.
// Optional macro INTRA_SEQ_TIMEOUT_EN bounds each predictor response wait by TIMEOUT cycles.
module intra_block_sequencer #(
    parameter int unsigned FRAME_W = 1920,
    parameter int unsigned FRAME_H = 1080,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   cfg_plane,
    input  logic                   cfg_use_filter_intra,
    input  logic [3:0]             cfg_mode,
    input  logic [9:0]             cfg_base_angle,
    input  logic [9:0]             cfg_angle_delta_y,
    input  logic [9:0]             cfg_angle_delta_uv,
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic [15:0]            x,
    output logic [15:0]            y,
    output logic [9:0]             log2W,
    output logic [9:0]             log2H,
    output logic                   haveLeft,
    output logic                   haveAbove,
    output logic                   haveAboveRight,
    output logic                   haveBelowLeft,
    output logic                   plane,
    output logic                   use_filter_intra,
    output logic [3:0]             mode,
    output logic [9:0]             base_angle,
    output logic [9:0]             AngleDeltaY,
    output logic [9:0]             AngleDeltaUV,
    input  logic                   pred_valid,
    input  logic [0:3][0:3][9:0]   pred_in,
    output logic                   blk_valid,
    input  logic                   blk_ready,
    output logic [0:3][0:3][9:0]   blk_data,
    output logic [15:0]            blk_x,
    output logic [15:0]            blk_y,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [15:0]          r_x;
    logic [15:0]          r_y;
    logic                 r_req_valid;
    logic                 r_blk_valid;
    logic [0:3][0:3][9:0] r_blk_data;
    logic [15:0]          r_blk_x;
    logic [15:0]          r_blk_y;
    logic                 r_busy;
    logic                 r_frame_done;
    logic                 r_plane;
    logic                 r_use_filter_intra;
    logic [3:0]           r_mode;
    logic [9:0]           r_base_angle;
    logic [9:0]           r_angle_delta_y;
    logic [9:0]           r_angle_delta_uv;

    logic                 w_last_col;
    logic                 w_last_row;

`ifdef INTRA_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0]     r_wait_cnt;
    logic                 r_timeout_err;
`else
    logic                 w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
`endif

    assign w_last_col = ((32'(r_x) + 32'd4) == FRAME_W);
    assign w_last_row = ((32'(r_y) + 32'd4) == FRAME_H);

    assign haveLeft       = (r_x != '0);
    assign haveAbove      = (r_y != '0);
    assign haveAboveRight = (r_y != '0) && ((32'(r_x) + 32'd4) < FRAME_W);
    assign haveBelowLeft  = (r_x != '0) && ((32'(r_y) + 32'd4) < FRAME_H);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= S_IDLE;
            r_x                <= '0;
            r_y                <= '0;
            r_req_valid        <= 1'b0;
            r_blk_valid        <= 1'b0;
            r_blk_data         <= '0;
            r_blk_x            <= '0;
            r_blk_y            <= '0;
            r_busy             <= 1'b0;
            r_frame_done       <= 1'b0;
            r_plane            <= 1'b0;
            r_use_filter_intra <= 1'b0;
            r_mode             <= '0;
            r_base_angle       <= '0;
            r_angle_delta_y    <= '0;
            r_angle_delta_uv   <= '0;
`ifdef INTRA_SEQ_TIMEOUT_EN
            r_wait_cnt         <= '0;
            r_timeout_err      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_plane            <= cfg_plane;
                        r_use_filter_intra <= cfg_use_filter_intra;
                        r_mode             <= cfg_mode;
                        r_base_angle       <= cfg_base_angle;
                        r_angle_delta_y    <= cfg_angle_delta_y;
                        r_angle_delta_uv   <= cfg_angle_delta_uv;
                        r_x                <= '0;
                        r_y                <= '0;
                        r_req_valid        <= 1'b1;
                        r_busy             <= 1'b1;
                        r_state            <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (r_req_valid && req_ready) begin
                        r_req_valid <= 1'b0;
`ifdef INTRA_SEQ_TIMEOUT_EN
                        r_wait_cnt  <= '0;
`endif
                        r_state     <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (pred_valid) begin
                        r_blk_data  <= pred_in;
                        r_blk_x     <= r_x;
                        r_blk_y     <= r_y;
                        r_blk_valid <= 1'b1;
                        r_state     <= S_EMIT;
                    end
`ifdef INTRA_SEQ_TIMEOUT_EN
                    else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // Substitute mid-grey so the walk can continue past a silent predictor.
                        r_blk_data    <= {16{10'd512}};
                        r_blk_x       <= r_x;
                        r_blk_y       <= r_y;
                        r_blk_valid   <= 1'b1;
                        r_timeout_err <= 1'b1;
                        r_state       <= S_EMIT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
`endif
                end

                S_EMIT: begin
                    if (r_blk_valid && blk_ready) begin
                        r_blk_valid <= 1'b0;
                        if (w_last_col && w_last_row) begin
                            // Coordinates park at the origin so idle flags read as reset.
                            r_x          <= '0;
                            r_y          <= '0;
                            r_frame_done <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            if (w_last_col) begin
                                r_x <= '0;
                                r_y <= r_y + 16'd4;
                            end else begin
                                r_x <= r_x + 16'd4;
                            end
                            r_req_valid <= 1'b1;
                            r_state     <= S_ISSUE;
                        end
                    end
                end

                S_DONE: begin
                    r_frame_done <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_valid        = r_req_valid;
    assign x                = r_x;
    assign y                = r_y;
    assign log2W            = 10'd2;
    assign log2H            = 10'd2;
    assign plane            = r_plane;
    assign use_filter_intra = r_use_filter_intra;
    assign mode             = r_mode;
    assign base_angle       = r_base_angle;
    assign AngleDeltaY      = r_angle_delta_y;
    assign AngleDeltaUV     = r_angle_delta_uv;
    assign blk_valid        = r_blk_valid;
    assign blk_data         = r_blk_data;
    assign blk_x            = r_blk_x;
    assign blk_y            = r_blk_y;
    assign busy             = r_busy;
    assign frame_done       = r_frame_done;
`ifdef INTRA_SEQ_TIMEOUT_EN
    assign timeout_err      = r_timeout_err;
`else
    assign timeout_err      = 1'b0;
`endif

endmodule

// File: tb/tb_intra_block_sequencer.sv
// Self-checking bench for intra_block_sequencer on an 8x8 frame (4 blocks).
// Table-driven frames, directed reset/timeout sequences and randomized frames against a coordinate model.
module tb_intra_block_sequencer;

    localparam int unsigned FW   = 8;
    localparam int unsigned FH   = 8;
    localparam int unsigned TO   = 10;
    localparam int          NBLK = (FW / 4) * (FH / 4);

    typedef logic [0:3][0:3][9:0] blk_t;

    typedef struct {
        int          rw;
        int          pw;
        int          bw;
        bit          bs;
        logic [15:0] ex;
        logic [15:0] ey;
        logic [3:0]  ef;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        cfg_plane = 1'b0;
    logic        cfg_use_filter_intra = 1'b0;
    logic [3:0]  cfg_mode = '0;
    logic [9:0]  cfg_base_angle = '0;
    logic [9:0]  cfg_angle_delta_y = '0;
    logic [9:0]  cfg_angle_delta_uv = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [15:0] x, y;
    logic [9:0]  log2W, log2H;
    logic        haveLeft, haveAbove, haveAboveRight, haveBelowLeft;
    logic        plane, use_filter_intra;
    logic [3:0]  mode;
    logic [9:0]  base_angle, AngleDeltaY, AngleDeltaUV;
    logic        pred_valid = 1'b0;
    blk_t        pred_in = '0;
    logic        blk_valid;
    logic        blk_ready = 1'b0;
    blk_t        blk_data;
    logic [15:0] blk_x, blk_y;
    logic        busy, frame_done, timeout_err;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          frame_c0 = 0;
    int          frame_cycles = 0;
    bit          exp_terr = 1'b0;
    logic [35:0] e_cfg = '0;
    vec_t        tbl [4];

    always #5 clk = ~clk;

    intra_block_sequencer #(
        .FRAME_W (FW),
        .FRAME_H (FH),
        .TIMEOUT (TO)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start),
        .cfg_plane            (cfg_plane),
        .cfg_use_filter_intra (cfg_use_filter_intra),
        .cfg_mode             (cfg_mode),
        .cfg_base_angle       (cfg_base_angle),
        .cfg_angle_delta_y    (cfg_angle_delta_y),
        .cfg_angle_delta_uv   (cfg_angle_delta_uv),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .x                    (x),
        .y                    (y),
        .log2W                (log2W),
        .log2H                (log2H),
        .haveLeft             (haveLeft),
        .haveAbove            (haveAbove),
        .haveAboveRight       (haveAboveRight),
        .haveBelowLeft        (haveBelowLeft),
        .plane                (plane),
        .use_filter_intra     (use_filter_intra),
        .mode                 (mode),
        .base_angle           (base_angle),
        .AngleDeltaY          (AngleDeltaY),
        .AngleDeltaUV         (AngleDeltaUV),
        .pred_valid           (pred_valid),
        .pred_in              (pred_in),
        .blk_valid            (blk_valid),
        .blk_ready            (blk_ready),
        .blk_data             (blk_data),
        .blk_x                (blk_x),
        .blk_y                (blk_y),
        .busy                 (busy),
        .frame_done           (frame_done),
        .timeout_err          (timeout_err)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Raster walk: block b sits at column b % (W/4), row b / (W/4).
    function automatic void model(input int b, output logic [15:0] ex, output logic [15:0] ey,
                                  output logic [3:0] ef);
        int bx;
        int by;
        bx = (b % (FW / 4)) * 4;
        by = (b / (FW / 4)) * 4;
        ex = 16'(bx);
        ey = 16'(by);
        ef = {bx != 0, by != 0, (by != 0) && (bx + 4 < FW), (bx != 0) && (by + 4 < FH)};
    endfunction

    function automatic blk_t rand_blk();
        blk_t v;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                v[r][c] = 10'($urandom_range(0, 1023));
        return v;
    endfunction

    function automatic blk_t seq_blk(input int b);
        blk_t v;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                v[r][c] = 10'(b * 16 + r * 4 + c + 100);
        return v;
    endfunction

    task automatic scramble_cfg();
        cfg_plane            = 1'($urandom_range(0, 1));
        cfg_use_filter_intra = 1'($urandom_range(0, 1));
        cfg_mode             = 4'($urandom_range(0, 15));
        cfg_base_angle       = 10'($urandom_range(0, 1023));
        cfg_angle_delta_y    = 10'($urandom_range(0, 1023));
        cfg_angle_delta_uv   = 10'($urandom_range(0, 1023));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctl"}, {req_valid, blk_valid, busy, frame_done, timeout_err}, '0);
        check({tag, "_coord"}, {x, y, blk_x, blk_y, haveLeft, haveAbove, haveAboveRight, haveBelowLeft}, '0);
        check({tag, "_cfg"}, {plane, use_filter_intra, mode, base_angle, AngleDeltaY, AngleDeltaUV}, '0);
        check({tag, "_data"}, blk_data, '0);
        check({tag, "_log2"}, {log2W, log2H}, {10'd2, 10'd2});
    endtask

    task automatic start_frame();
        check("idle_before_start", busy, 1'b0);
        scramble_cfg();
        e_cfg = {cfg_plane, cfg_use_filter_intra, cfg_mode, cfg_base_angle, cfg_angle_delta_y, cfg_angle_delta_uv};
        start = 1'b1;
        tick();
        start = 1'b0;
        scramble_cfg();
        check("start_req", {req_valid, busy}, 2'b11);
        frame_c0 = cyc;
    endtask

    task automatic do_block(input int b, input int rw, input int pw, input int bw, input blk_t data,
                            input bit bs, input logic [15:0] ex, input logic [15:0] ey, input logic [3:0] ef);
        int k;
        bit last;
        last = (b == NBLK - 1);
        k = 0;
        while (!req_valid && k < 20) begin
            tick();
            k++;
        end
        check("req_valid", req_valid, 1'b1);
        check("req_xy", {x, y}, {ex, ey});
        check("flags", {haveLeft, haveAbove, haveAboveRight, haveBelowLeft}, ef);
        check("cfg", {plane, use_filter_intra, mode, base_angle, AngleDeltaY, AngleDeltaUV}, e_cfg);
        check("log2", {log2W, log2H}, {10'd2, 10'd2});
        check("timeout_err", timeout_err, exp_terr);
        for (int i = 0; i < rw; i++) begin
            pred_valid = 1'($urandom_range(0, 1));
            pred_in    = rand_blk();
            tick();
            check("req_hold", {req_valid, blk_valid, x, y, haveLeft, haveAbove, haveAboveRight, haveBelowLeft,
                               plane, use_filter_intra, mode, base_angle, AngleDeltaY, AngleDeltaUV},
                              {2'b10, ex, ey, ef, e_cfg});
        end
        pred_valid = 1'b0;
        req_ready  = 1'b1;
        start      = bs;
        if (bs) scramble_cfg();
        tick();
        req_ready = 1'b0;
        start     = 1'b0;
        check("wait_entry", {req_valid, blk_valid, busy}, 3'b001);
        for (int i = 0; i < pw; i++) begin
            tick();
            check("wait_quiet", {req_valid, blk_valid}, 2'b00);
        end
        pred_in    = data;
        pred_valid = 1'b1;
        tick();
        pred_valid = 1'b0;
        pred_in    = rand_blk();
        check("blk_valid", blk_valid, 1'b1);
        check("blk_data", blk_data, data);
        check("blk_xy", {blk_x, blk_y}, {ex, ey});
        for (int i = 0; i < bw; i++) begin
            pred_valid = 1'($urandom_range(0, 1));
            pred_in    = rand_blk();
            tick();
            check("blk_hold", {blk_valid, req_valid, blk_x, blk_y, blk_data}, {2'b10, ex, ey, data});
        end
        pred_valid = 1'b0;
        blk_ready  = 1'b1;
        tick();
        blk_ready = 1'b0;
        if (!last) begin
            check("next_req", {blk_valid, req_valid, frame_done, busy}, 4'b0101);
        end else begin
            check("frame_done", {blk_valid, req_valid, frame_done, busy}, 4'b0011);
            frame_cycles = cyc - frame_c0;
            tick();
            check("done_idle", {frame_done, busy, req_valid}, 3'b000);
        end
    endtask

    task automatic reset_mid_frame();
        int k;
        logic [15:0] ex, ey;
        logic [3:0]  ef;
        start_frame();
        model(0, ex, ey, ef);
        do_block(0, 1, 1, 1, rand_blk(), 1'b0, ex, ey, ef);
        k = 0;
        while (!req_valid && k < 20) begin
            tick();
            k++;
        end
        check("rst_req1", {req_valid, x, y}, {1'b1, 16'd4, 16'd0});
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("rst_in_wait", {req_valid, blk_valid, busy}, 3'b001);
        pred_in = rand_blk();
        #2 rst_n = 1'b0;
        #1 check_reset("rst_mid");
        pred_valid = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        pred_valid = 1'b0;
        check_reset("rst_post");
        start_frame();
        for (int b = 0; b < NBLK; b++) begin
            model(b, ex, ey, ef);
            do_block(b, 0, 1, 0, rand_blk(), 1'b0, ex, ey, ef);
        end
    endtask

`ifdef INTRA_SEQ_TIMEOUT_EN
    task automatic timeout_frame();
        int k;
        logic [15:0] ex, ey;
        logic [3:0]  ef;
        start_frame();
        for (int b = 0; b < NBLK; b++) begin
            model(b, ex, ey, ef);
            k = 0;
            while (!req_valid && k < 20) begin
                tick();
                k++;
            end
            check("to_req", {req_valid, x, y, haveLeft, haveAbove, haveAboveRight, haveBelowLeft},
                            {1'b1, ex, ey, ef});
            req_ready = 1'b1;
            tick();
            req_ready = 1'b0;
            k = 0;
            while (!blk_valid && k < 30) begin
                tick();
                k++;
            end
            check("to_cycles", k, TO);
            check("to_data", blk_data, {16{10'd512}});
            check("to_err", timeout_err, 1'b1);
            check("to_xy", {blk_x, blk_y}, {ex, ey});
            blk_ready = 1'b1;
            tick();
            blk_ready = 1'b0;
        end
        check("to_done", {frame_done, busy}, 2'b11);
        tick();
        check("to_sticky", {timeout_err, busy, frame_done}, 3'b100);
        #2 rst_n = 1'b0;
        #1 check_reset("to_rst");
        tick();
        rst_n = 1'b1;
        tick();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500000ns");
        $fatal(1);
    end

    initial begin
        logic [15:0] ex, ey;
        logic [3:0]  ef;
        int          waits;

        tbl[0] = '{5, 0, 0, 1'b0, 16'd0, 16'd0, 4'b0000};
        tbl[1] = '{0, 2, 3, 1'b1, 16'd4, 16'd0, 4'b1001};
        tbl[2] = '{1, 1, 1, 1'b0, 16'd0, 16'd4, 4'b0110};
        tbl[3] = '{0, 4, 2, 1'b1, 16'd4, 16'd4, 4'b1100};

        #1 rst_n = 1'b0;
        #2 check_reset("por");
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check_reset("idle");

        // Zero-wait partners: 3 cycles per block.
        start_frame();
        for (int i = 0; i < NBLK; i++)
            do_block(i, 0, 0, 0, seq_blk(i), 1'b0, tbl[i].ex, tbl[i].ey, tbl[i].ef);
        check("frame1_cycles", frame_cycles, 3 * NBLK);

        start_frame();
        waits = 0;
        for (int i = 0; i < NBLK; i++) begin
            do_block(i, tbl[i].rw, tbl[i].pw, tbl[i].bw, seq_blk(i + 4), tbl[i].bs,
                     tbl[i].ex, tbl[i].ey, tbl[i].ef);
            waits += tbl[i].rw + tbl[i].pw + tbl[i].bw;
        end
        check("frame2_cycles", frame_cycles, 3 * NBLK + waits);

        reset_mid_frame();

        for (int f = 0; f < 6; f++) begin
            start_frame();
            for (int b = 0; b < NBLK; b++) begin
                model(b, ex, ey, ef);
                do_block(b, $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 3), rand_blk(),
                         ($urandom_range(0, 3) == 0), ex, ey, ef);
            end
        end

`ifdef INTRA_SEQ_TIMEOUT_EN
        timeout_frame();
        start_frame();
        for (int b = 0; b < NBLK; b++) begin
            model(b, ex, ey, ef);
            do_block(b, 0, 2, 0, rand_blk(), 1'b0, ex, ey, ef);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/intra_block_sequencer.md
# intra_block_sequencer

Frame-walking request generator for `intra_control`: the initiator that drives a predictor with block coordinates, neighbour-availability flags and mode fields, then collects the 4x4 prediction it returns. It walks the frame in raster order of 4x4 blocks and issues one request per block through a valid/ready handshake. It captures each `pred_out` and forwards it with its coordinates to the downstream reconstruction stage.

## Interface
Parameters:
- `FRAME_W`, 1920, frame width in pixels; multiple of 4.
- `FRAME_H`, 1080, frame height in pixels; multiple of 4.
- `TIMEOUT`, 255, cycle budget for a predictor response (used only with the macro).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a frame walk (ignored unless IDLE).
- `cfg_plane`, `cfg_use_filter_intra`  in  1 each  latched at start.
- `cfg_mode`  in  4  latched at start.
- `cfg_base_angle`, `cfg_angle_delta_y`, `cfg_angle_delta_uv`  in  10 each  latched at start.
- `req_valid`  out  1  request to predictor.
- `req_ready`  in  1  predictor accepts request.
- `x`, `y`  out  16 each  block origin in pixels.
- `log2W`, `log2H`  out  10 each  constant 2.
- `haveLeft`, `haveAbove`, `haveAboveRight`, `haveBelowLeft`  out  1 each  neighbour availability.
- `plane`, `use_filter_intra`, `mode`, `base_angle`, `AngleDeltaY`, `AngleDeltaUV`  out  latched cfg copies.
- `pred_valid`  in  1  `pred_in` holds the result for the outstanding request.
- `pred_in`  in  10 [0:3][0:3]  predicted samples.
- `blk_valid`  out  1  captured block available downstream.
- `blk_ready`  in  1  downstream accepts block.
- `blk_data`  out  10 [0:3][0:3]  captured samples.
- `blk_x`, `blk_y`  out  16 each  origin of `blk_data`.
- `busy`  out  1  high in any state but IDLE.
- `frame_done`  out  1  one-cycle pulse after the last block is accepted.
- `timeout_err`  out  1  sticky error flag (macro only; otherwise tied 0).

## Operation
- FSM: IDLE → ISSUE → WAIT → EMIT → (ISSUE | DONE) → IDLE.
- IDLE: on `start`, latch cfg, set x=y=0, go to ISSUE.
- ISSUE: `req_valid`=1. Hold all request outputs stable until `req_valid && req_ready`, then go to WAIT.
- WAIT: on `pred_valid`, register `pred_in` into `blk_data` with `blk_x`=x and `blk_y`=y, then go to EMIT. A `pred_valid` in any other state is ignored.
- EMIT: `blk_valid`=1 until `blk_ready`. On the handshake, advance x+=4. If x+4==FRAME_W, set x=0 and y+=4. If the block was the last (x==FRAME_W-4, y==FRAME_H-4), go to DONE; otherwise go to ISSUE.
- DONE: pulse `frame_done` for one cycle, go to IDLE.
- Availability, combinational from x/y:
  - haveLeft = x≠0
  - haveAbove = y≠0
  - haveAboveRight = y≠0 && x+4<FRAME_W
  - haveBelowLeft = x≠0 && y+4<FRAME_H
- Coordinate arithmetic is 16-bit unsigned; no wrap is possible for legal parameters.
- `start` while busy has no effect.

## Timing
- Reset values: all outputs 0, `log2W`/`log2H`=2, state IDLE, `blk_data` all 0.
- `start` at edge N: `req_valid` is high from cycle N+1.
- Request to capture: 1 cycle after `pred_valid` is sampled, `blk_valid` rises.
- After the `blk_ready` handshake, the next `req_valid` rises the following cycle. Minimum 3 cycles per block with zero-wait partners.
- `rst_n` asserted mid-frame: immediate return to IDLE and all outputs to reset values. Any outstanding predictor response is discarded.

## Configuration
- `INTRA_SEQ_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT and clears on entry to WAIT.
  - If it reaches `TIMEOUT` with no `pred_valid`, fill `blk_data` with 512 in all samples, set `timeout_err` (sticky until reset) and go to EMIT.
- Undefined: WAIT waits indefinitely; counter logic absent; `timeout_err` is 0.

## Test plan
- FRAME_W=8, FRAME_H=8, zero-wait predictor: start produces 4 requests.
  - (x,y) sequence: (0,0) (4,0) (0,4) (4,4).
  - Flags [L,A,AR,BL] in that order: 0000, 1001, 0110, 1100.
  - `frame_done` pulses once after the 4th `blk_ready`.
- `req_ready` held low 5 cycles in ISSUE: x, y, flags and mode stay stable; exactly one WAIT entry follows.
- `pred_in` = 16 distinct values with `blk_ready` delayed 3 cycles: `blk_data` matches the values and stays stable; no new request issues until accept.
- `rst_n` pulled low during WAIT of block 2: all outputs return to 0 (`log2W`/`log2H`=2); a later `start` restarts at (0,0).
- `start` pulsed while busy: no effect on the sequence or the block count.
- With `INTRA_SEQ_TIMEOUT_EN`, TIMEOUT=10, `pred_valid` never asserted:
  - After 10 WAIT cycles, `blk_data` is all 512 and `timeout_err`=1.
  - The walk continues to completion.
